// File: rtl/queue_serializer.sv
// Drains the synchronous queue one word at a time and shifts each word out as a serial frame.
// Define QUEUE_SERIALIZER_PARITY_EN to append an even-parity bit before the stop bit (WL >= 2).
module queue_serializer #(
    parameter int unsigned WL           = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EMPTY,
    input  logic          ERROR,
    input  logic [WL-1:0] din,
    output logic          rReq,
    output logic          txd,
    output logic          busy,
    output logic          frame_done,
    output logic          drop
);
    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = $clog2(WL + 1);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] BaudPen  = BaudW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
    localparam logic [BitW-1:0]  BitLast  = BitW'(WL - 1);
    localparam bit               OneCyc   = (CLKS_PER_BIT == 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StFetch,
        StStart,
        StData,
`ifdef QUEUE_SERIALIZER_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e            state_q;
    logic [WL-1:0]     shreg_q;
    logic [BaudW-1:0]  baud_q;
    logic [BitW-1:0]   bit_q;
`ifdef QUEUE_SERIALIZER_PARITY_EN
    logic              par_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            rReq       <= 1'b0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            drop       <= 1'b0;
            shreg_q    <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
`ifdef QUEUE_SERIALIZER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            rReq       <= 1'b0;
            frame_done <= 1'b0;
            drop       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    txd <= 1'b1;
                    if (!EMPTY) begin
                        state_q <= StReq;
                        rReq    <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                StReq: state_q <= StFetch;
                StFetch: begin
                    if (ERROR) begin
                        state_q <= StIdle;
                        drop    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state_q <= StStart;
                        shreg_q <= din;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txd     <= 1'b0;
`ifdef QUEUE_SERIALIZER_PARITY_EN
                        par_q   <= ^din;
`endif
                    end
                end
                StStart: begin
                    if (baud_q == BaudLast) begin
                        baud_q  <= '0;
                        txd     <= shreg_q[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_q == BaudLast) begin
                        baud_q  <= '0;
                        shreg_q <= shreg_q >> 1;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BitLast) begin
`ifdef QUEUE_SERIALIZER_PARITY_EN
                            txd     <= par_q;
                            state_q <= StParity;
`else
                            txd        <= 1'b1;
                            state_q    <= StStop;
                            frame_done <= OneCyc;
`endif
                        end else begin
                            // txd is registered, so present the bit that lands in [0] after the shift
                            txd <= shreg_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef QUEUE_SERIALIZER_PARITY_EN
                StParity: begin
                    if (baud_q == BaudLast) begin
                        baud_q     <= '0;
                        txd        <= 1'b1;
                        state_q    <= StStop;
                        frame_done <= OneCyc;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (baud_q == BaudLast) begin
                        baud_q  <= '0;
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        baud_q     <= baud_q + 1'b1;
                        // Raise one cycle early so the registered pulse covers the last STOP cycle
                        frame_done <= (baud_q == BaudPen);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    txd     <= 1'b1;
                end
            endcase
        end
    end

endmodule
